// File: rtl/qmult_seq.sv
// qmult_seq: sequential sign-magnitude fixed-point multiplier.
// Operands and product use the same format: bit N-1 is the sign, bits N-2:0 are
// the magnitude with Q fractional bits. One multiplier bit is consumed per clock
// (shift-add, LSB first), then one finalize cycle extracts, saturates and signs
// the product. Valid/ready handshakes on both the operand and result sides.
// Build option: define QMULT_ROUND_EN to round half-up on the magnitude
// instead of truncating the discarded fractional bits.
module qmult_seq #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow
);

  localparam int M  = N - 1;          // magnitude width
  localparam int PW = 2 * M;          // full product width
  localparam int CW = $clog2(N);      // counter must reach M

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [PW-1:0] acc_reg;
  logic [PW-1:0] mcand_reg;
  logic [M-1:0]  mplier_reg;
  logic          sign_reg;
  logic [CW-1:0] count_reg;
  logic [N-1:0]  result_reg;
  logic          overflow_reg;

  logic          accept;
  logic          last;
  logic [PW-1:0] addend;
  logic [PW-1:0] prod_adj;
  logic [PW-1:0] prod_shifted;
  logic          ovf_next;
  logic [M-1:0]  mag_next;
  logic          sign_next;

  assign accept = in_valid && (state_reg == IDLE);
  // Count M marks the cycle after the final iteration: the finalize step.
  assign last   = (count_reg == CW'(M));

  // Gate the shifted multiplicand by the current multiplier bit.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

`ifdef QMULT_ROUND_EN
  // Half an output LSB; the accumulator cannot wrap since (2^M-1)^2 + 2^(Q-1) < 2^PW.
  localparam logic [PW-1:0] HALF = PW'(1) << (Q - 1);
  assign prod_adj = acc_reg + HALF;
`else
  assign prod_adj = acc_reg;
`endif

  // Extract the magnitude field, saturating if any bit above it is set.
  always_comb begin
    prod_shifted = prod_adj >> Q;
    ovf_next     = |prod_shifted[PW-1:M];
    mag_next     = ovf_next ? {M{1'b1}} : prod_shifted[M-1:0];
    sign_next    = sign_reg && (mag_next != '0);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, finish after the finalize cycle, drain on out_ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands, run shift-add iterations, then register the final product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      sign_reg     <= 1'b0;
      count_reg    <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg    <= '0;
            mcand_reg  <= PW'(a[M-1:0]);
            mplier_reg <= b[M-1:0];
            sign_reg   <= a[N-1] ^ b[N-1];
            count_reg  <= '0;
          end
        end
        BUSY: begin
          if (!last) begin
            acc_reg    <= acc_reg + addend;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + CW'(1);
          end else begin
            result_reg   <= {sign_next, mag_next};
            overflow_reg <= ovf_next;
          end
        end
        default: begin
          // DONE: hold result until the consumer takes it.
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_qmult_seq.sv
// tb_qmult_seq: table vectors, handshake hold, mid-operation reset and random
// operands checked against an arithmetic reference of the product.
module tb_qmult_seq;

  localparam int N = 32;
  localparam int Q = 15;
`ifdef QMULT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic         overflow;

  int compared = 0;
  int mismatched = 0;

  qmult_seq #(.N(N), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact product of magnitudes, optional half-LSB, scale, saturate.
  function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                output logic [N-1:0] r, output logic o);
    longint unsigned x, y, p, t;
    logic [N-2:0] mag;
    x = longint'(ma[N-2:0]);
    y = longint'(mb[N-2:0]);
    p = x * y;
    if (ROUND) p = p + (64'd1 << (Q - 1));
    t = p >> Q;
    o = (t > 64'h7FFF_FFFF);
    mag = o ? 31'h7FFF_FFFF : t[N-2:0];
    r = {(ma[N-1] ^ mb[N-1]) && (mag != '0), mag};
  endfunction

  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    check("in_ready_busy", in_ready, 0);
  endtask

  // Counts edges after acceptance until out_valid is seen; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);
  endtask

  initial begin
    int lat;
    logic [N-1:0] r0, er, ra, rb;
    logic eo;

    vecs[0] = '{32'h0000C000, 32'h00010000, 32'h00018000, 1'b0};
    vecs[1] = '{32'h8000C000, 32'h00010000, 32'h80018000, 1'b0};
    vecs[2] = '{32'h00000000, 32'h80008000, 32'h00000000, 1'b0};
    vecs[3] = '{32'h40000000, 32'h00010000, 32'h7FFFFFFF, 1'b1};
    vecs[4] = '{32'hC0000000, 32'h00010000, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{32'h00000001, 32'h00004000, ROUND ? 32'h00000001 : 32'h00000000, 1'b0};
    vecs[6] = '{32'h80008000, 32'h80008000, 32'h00008000, 1'b0};
    vecs[7] = '{32'h80000001, 32'h00004000, ROUND ? 32'h80000001 : 32'h00000000, 1'b0};
    vecs[8] = '{32'h7FFFFFFF, 32'h00008000, 32'h7FFFFFFF, 1'b0};

    // Reset state
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_overflow", overflow, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat);
      check("latency", lat, N);
      check("result", result, vecs[i].res);
      check("overflow", overflow, vecs[i].ovf);
      $display("vec %0d: a=%h b=%h result=%h ovf=%0d lat=%0d", i, vecs[i].a, vecs[i].b, result, overflow, lat);
      release_out();
    end

    // Hold in DONE for 5 cycles with out_ready low and new operands offered
    start_op(32'h0000C000, 32'h00010000);
    wait_done(lat);
    check("hold_latency", lat, N);
    r0 = result;
    check("hold_result_initial", r0, 32'h00018000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h00010000;
      b = 32'h00010000;
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", result, r0);
    end
    release_out();
    $display("hold: result=%h stable for 5 cycles, back in IDLE", r0);
    start_op(32'h00008000, 32'h00018000);
    wait_done(lat);
    check("after_hold_result", result, 32'h00018000);
    release_out();

    // Reset mid-BUSY
    start_op(32'h0000C000, 32'h00010000);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    check("midrst_no_out_valid", lat, 0);
    start_op(32'h8000C000, 32'h00010000);
    wait_done(lat);
    check("midrst_next_latency", lat, N);
    check("midrst_next_result", result, 32'h80018000);
    $display("reset mid-busy: next result=%h", result);
    release_out();

    // Random operands against the reference model, random consumer stalls
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      ra[N-2:0] = ra[N-2:0] >> $urandom_range(0, 30);
      rb[N-2:0] = rb[N-2:0] >> $urandom_range(0, 30);
      model(ra, rb, er, eo);
      start_op(ra, rb);
      wait_done(lat);
      check("rand_latency", lat, N);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      check("rand_result", result, er);
      check("rand_overflow", overflow, eo);
      $display("rand %0d: a=%h b=%h result=%h ovf=%0d", i, ra, rb, result, overflow);
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
